// File: rtl/sub_seq_clk_if.sv
// Start/busy/done handshake and operand/result bus for the sliced subtractor.
// The controller drives the master side and the subtractor owns the slave side.
interface sub_seq_clk_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             ov;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo, ov
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo, ov
    );
endinterface

// File: rtl/sub_seq_clk.sv
// Multi-cycle subtractor d = a - b - bi, one SLICE-bit slice per clock, LSB first.
// The results are registered at the DONE-entry edge, so partial slices are never visible.
module sub_seq_clk #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    sub_seq_clk_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [NSLICE-1:0][SLICE-1:0]  r_a;
    logic [NSLICE-1:0][SLICE-1:0]  r_b;
    logic [NSLICE-1:0][SLICE-1:0]  r_acc;
    logic                          r_borrow;
    logic [CNT_W-1:0]              r_cnt;
    logic [WIDTH-1:0]              r_d;
    logic                          r_bo;
    logic                          r_ov;

    logic [SLICE:0]                w_sum;
    logic                          w_borrow_nxt;
    logic                          w_last;
    logic                          w_ov;
    logic [NSLICE-1:0][SLICE-1:0]  w_acc_full;

    // Slice subtract as a + ~b + ~borrow; carry-out low means a borrow into the next slice
    always_comb begin
        w_sum        = {1'b0, r_a[r_cnt]} + {1'b0, ~r_b[r_cnt]} + {{SLICE{1'b0}}, ~r_borrow};
        w_borrow_nxt = ~w_sum[SLICE];
        w_last       = (r_cnt == LAST_CNT);
        w_acc_full   = r_acc;
        w_acc_full[r_cnt] = w_sum[SLICE-1:0];
        w_ov         = (r_a[NSLICE-1][SLICE-1] != r_b[NSLICE-1][SLICE-1]) &&
                       (w_acc_full[NSLICE-1][SLICE-1] != r_a[NSLICE-1][SLICE-1]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE:                w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, slice accumulation and result load
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_bo     <= 1'b0;
            r_ov     <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start) begin
                r_a      <= bus.a;
                r_b      <= bus.b;
                r_borrow <= bus.bi;
                r_cnt    <= '0;
            end
        end else if (r_state == ST_CALC) begin
            r_acc[r_cnt] <= w_sum[SLICE-1:0];
            r_borrow     <= w_borrow_nxt;
            r_cnt        <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_d  <= w_acc_full;
                r_bo <= w_borrow_nxt;
                r_ov <= w_ov;
            end
        end
    end

    // busy/done decode straight from the state flops
    assign bus.busy = (r_state == ST_CALC);
    assign bus.done = (r_state == ST_DONE);
    assign bus.d    = r_d;
    assign bus.bo   = r_bo;
    assign bus.ov   = r_ov;

endmodule

// File: tb/tb_sub_seq_clk.sv
// Directed bench for sub_seq_clk: latency, borrow/overflow corners, ignored starts,
// mid-operation reset and back-to-back issue.
module tb_sub_seq_clk;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    sub_seq_clk_if #(.WIDTH(32)) bus ();

    sub_seq_clk #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one op at the next negedge; returns done latency (edges after sampling edge) and busy cycles
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.bi = bi;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bi = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.d !== 32'h0) begin n_err++; $display("FAIL reset_d got=%h exp=0", bus.d); end
        n_cmp++; if ({bus.bo, bus.ov} !== 2'b00) begin n_err++; $display("FAIL reset_bo_ov got=%b exp=00", {bus.bo, bus.ov}); end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat, bc;
        issue(32'd5, 32'd3, 1'b0, lat, bc);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
        n_cmp++; if (bus.d !== 32'h00000002) begin n_err++; $display("FAIL basic_d got=%h exp=00000002", bus.d); end
        n_cmp++; if ({bus.bo, bus.ov} !== 2'b00) begin n_err++; $display("FAIL basic_bo_ov got=%b exp=00", {bus.bo, bus.ov}); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_width got=%b exp=0", bus.done); end
    endtask

    task automatic test_underflow();
        int lat, bc;
        issue(32'h00000000, 32'h00000001, 1'b0, lat, bc);
        n_cmp++; if (bus.d !== 32'hFFFFFFFF) begin n_err++; $display("FAIL uflow_d got=%h exp=ffffffff", bus.d); end
        n_cmp++; if ({bus.bo, bus.ov} !== 2'b10) begin n_err++; $display("FAIL uflow_bo_ov got=%b exp=10", {bus.bo, bus.ov}); end
        issue(32'h80000000, 32'h00000001, 1'b0, lat, bc);
        n_cmp++; if (bus.d !== 32'h7FFFFFFF) begin n_err++; $display("FAIL sovf_d got=%h exp=7fffffff", bus.d); end
        n_cmp++; if ({bus.bo, bus.ov} !== 2'b01) begin n_err++; $display("FAIL sovf_bo_ov got=%b exp=01", {bus.bo, bus.ov}); end
        issue(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bc);
        n_cmp++; if (bus.d !== 32'h80000000) begin n_err++; $display("FAIL both_d got=%h exp=80000000", bus.d); end
        n_cmp++; if ({bus.bo, bus.ov} !== 2'b11) begin n_err++; $display("FAIL both_bo_ov got=%b exp=11", {bus.bo, bus.ov}); end
    endtask

    task automatic test_borrow_in();
        int lat, bc;
        issue(32'h00000100, 32'h000000FF, 1'b1, lat, bc);
        n_cmp++; if (bus.d !== 32'h00000000) begin n_err++; $display("FAIL ripple_d got=%h exp=00000000", bus.d); end
        n_cmp++; if ({bus.bo, bus.ov} !== 2'b00) begin n_err++; $display("FAIL ripple_bo_ov got=%b exp=00", {bus.bo, bus.ov}); end
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat, bc);
        n_cmp++; if (bus.d !== 32'hFFFFFFFF) begin n_err++; $display("FAIL bi_all_d got=%h exp=ffffffff", bus.d); end
        n_cmp++; if ({bus.bo, bus.ov} !== 2'b10) begin n_err++; $display("FAIL bi_all_bo_ov got=%b exp=10", {bus.bo, bus.ov}); end
        issue(32'h12345678, 32'h01010101, 1'b1, lat, bc);
        n_cmp++; if (bus.d !== 32'h11335576) begin n_err++; $display("FAIL bi_mix_d got=%h exp=11335576", bus.d); end
    endtask

    task automatic test_ignore_start();
        int lat, n_done, n_dchg;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd10; bus.b = 32'd4; bus.bi = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 32'd55; bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd1; bus.bi = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int k = 2; k < 12; k++) begin
            if (bus.done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL ign_latency got=%0d exp=4", lat); end
        n_cmp++; if (bus.d !== 32'd6) begin n_err++; $display("FAIL ign_d got=%h exp=00000006", bus.d); end
        bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd1;
        @(negedge clk);
        bus.start = 1'b0;
        n_done = 0;
        n_dchg = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done || bus.busy) n_done++;
            if (bus.d !== 32'd6) n_dchg++;
            @(negedge clk);
        end
        n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL ign_extra_activity got=%0d exp=0", n_done); end
        n_cmp++; if (n_dchg !== 0) begin n_err++; $display("FAIL ign_d_hold got=%0d exp=0", n_dchg); end
    endtask

    task automatic test_reset_abort();
        int lat, bc, n_done;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd20; bus.b = 32'd3; bus.bi = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.d !== 32'h0) begin n_err++; $display("FAIL abort_d got=%h exp=0", bus.d); end
        @(negedge clk);
        reset_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.done) n_done++;
            @(negedge clk);
        end
        n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        issue(32'd7, 32'd2, 1'b0, lat, bc);
        n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL post_abort_latency got=%0d exp=4", lat); end
        n_cmp++; if (bus.d !== 32'd5) begin n_err++; $display("FAIL post_abort_d got=%h exp=00000005", bus.d); end
    endtask

    task automatic test_back_to_back();
        int t_done[4];
        int n_seen, n_bad_d;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h12345678; bus.b = 32'h11111111; bus.bi = 1'b0;
        n_seen = 0;
        n_bad_d = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done && n_seen < 4) begin
                t_done[n_seen] = k;
                n_seen++;
                if (bus.d !== 32'h01234567 || bus.bo !== 1'b0 || bus.ov !== 1'b0) n_bad_d++;
            end
        end
        bus.start = 1'b0;
        n_cmp++; if (n_seen !== 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", n_seen); end
        n_cmp++; if (n_bad_d !== 0) begin n_err++; $display("FAIL b2b_result bad=%0d exp=0", n_bad_d); end
        if (n_seen == 4) begin
            n_cmp++; if (t_done[0] !== 4) begin n_err++; $display("FAIL b2b_first got=%0d exp=4", t_done[0]); end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (t_done[i] - t_done[i-1] !== 6) begin
                    n_err++; $display("FAIL b2b_period got=%0d exp=6", t_done[i] - t_done[i-1]);
                end
            end
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_underflow();
        test_borrow_in();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sub_seq_clk.md
Name: sub_seq_clk

Overview:
- Registered, multi-cycle 32-bit subtractor: computes d = a - b - bi, the inverse operation of the team's registered ripple-carry adder.
- Works one 8-bit slice per clock, LSB first, with the borrow held in a flop between slices.
- Uses a start/busy/done handshake so datapath controllers can issue subtractions and collect results at a known latency.
- Sits beside the adder in the ALU datapath test area.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits processed per cycle; WIDTH must be an integer multiple of SLICE.
- NSLICE, WIDTH/SLICE (4), number of compute cycles; derived, not overridable.

Ports:
- clk  input  1  clock, all flops on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bi  input  1  borrow in
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse when the result is valid
- d  output  WIDTH  difference (registered)
- bo  output  1  borrow out: 1 iff a < b + bi, unsigned
- ov  output  1  signed overflow: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB])

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; busy=0, done=0, d=0, bo=0, ov=0; internal operand, accumulator, borrow and slice-counter registers cleared.
- Reset asserted mid-operation aborts the operation immediately. No done is issued, and the next start after reset release runs normally.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1: capture a, b and bi into internal registers, set cnt=0, go to CALC.
  - With start=0: remain in IDLE.
- CALC, each edge:
  - Compute slice cnt = a_slice + ~b_slice + ~borrow (borrow initialised to bi).
  - Write the 8-bit result into accumulator slice cnt; borrow <= NOT(slice carry-out); cnt++.
  - On the edge where cnt==NSLICE-1: go to DONE, and load d from the full accumulator, bo from the final borrow and ov per the port definition.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE. start is ignored in DONE.
- Latency: start sampled at edge E → slices computed at edges E+1..E+4 → d/bo/ov/done updated at edge E+4; done low again after E+5. Earliest next start is sampled at E+6 (one op per 6 cycles).
- busy = (state==CALC); combinational decode of the state register, glitch-free because it comes from flops.
- start asserted while busy or in DONE: ignored, with no queuing. The in-flight operation is unaffected.
- Input changes on a/b/bi after the capture edge have no effect on the in-flight operation.
- d, bo and ov hold the previous result through IDLE and CALC. They change only at the DONE-entry edge (or on reset), never showing partial slices.
- Wrap-around: the result is modulo 2^WIDTH; bo carries the unsigned underflow.
- bi=1 is treated as an extra subtrahend of 1.

Test Plan:
- Reset, then a=5, b=3, bi=0, start pulse → done exactly 4 edges after the sampling edge; d=0x00000002, bo=0, ov=0; busy high for 4 cycles.
- a=0, b=1, bi=0 → d=0xFFFFFFFF, bo=1, ov=0. Then a=0x80000000, b=1 → d=0x7FFFFFFF, bo=0, ov=1.
- a=0x00000100, b=0x000000FF, bi=1 → d=0x00000000, bo=0, ov=0 (borrow ripples across the slice 0→1 boundary). Also a=0xFFFFFFFF, b=0xFFFFFFFF, bi=1 → d=0xFFFFFFFF, bo=1.
- Start an op (a=10, b=4); pulse start with a=100, b=1 during CALC and during DONE; change a/b mid-op → single done pulse with d=0x00000006. The second start is ignored, and d holds 6 through the following idle cycles.
- Drop reset_n for 1 cycle at the second CALC cycle → outputs immediately 0, no done. After release, start a=7, b=2 → d=5 with the normal 4-cycle latency.
- Back-to-back: hold start=1 continuously with fixed operands → done pulses exactly every 6 cycles with identical results.
